// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
// Optional event counters in hazard_ctrl are enabled with `define HAZARD_CNT_EN.
package hazard_pkg;

   // Controller FSM: free-running, or holding PC while a control transfer resolves.
   typedef enum logic [0:0] {
      RUN    = 1'b0,
      J_WAIT = 1'b1
   } state_e;

   // x0 is hard-wired to zero, so a load into it never creates a dependency.
   localparam logic [4:0] REG_ZERO = 5'd0;

   // Default number of cycles PC is held after a jump/branch decodes in ID.
   localparam int RES_LAT_DEFAULT = 2;

endpackage

// File: rtl/sat_cnt.sv
// sat_cnt: W-bit incrementer that sticks at all-ones instead of wrapping.
// Used by hazard_ctrl for its optional event counters (HAZARD_CNT_EN).
module sat_cnt #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: step by one on request, hold once saturated.
   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use detection between ID and EX, plus a fixed-latency PC
// hold after a jump/branch decodes in ID. Optional performance counters
// lu_cnt / j_cnt exist only when HAZARD_CNT_EN is defined.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int RES_LAT = RES_LAT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        id_valid,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_re1,
   input  logic        id_re2,
   input  logic        id_jump,
   input  logic        ex_valid,
   input  logic        ex_mem_read,
   input  logic [4:0]  ex_rd,
   output logic        stall,
   output logic        stall_j,
   output logic        bubble,
   output logic        flush_if,
   output logic        busy
`ifdef HAZARD_CNT_EN
   ,
   output logic [31:0] lu_cnt,
   output logic [31:0] j_cnt
`endif
);

   // Counter wide enough to hold RES_LAT; J_WAIT uses values RES_LAT-1 .. 1.
   localparam int                CNT_W    = $clog2(RES_LAT + 1);
   localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(RES_LAT - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   state_e           state_q;
   state_e           state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   logic lu;
   logic jd;
   logic stall_raw;
   logic stall_j_raw;
   logic bubble_raw;
   logic flush_raw;
   logic busy_raw;

   // Load in EX whose result ID needs now; x0 never counts as a dependency.
   assign lu = ex_valid & ex_mem_read & (ex_rd != REG_ZERO) & id_valid &
               ((id_re1 & (id_rs1 == ex_rd)) | (id_re2 & (id_rs2 == ex_rd)));

   // A jump only counts once ID is free of a load-use hazard; otherwise it is
   // picked up again after the bubble goes in.
   assign jd = id_valid & id_jump & ~lu;

   // State and countdown registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: enter J_WAIT for the remaining RES_LAT-1 hold cycles.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         RUN: begin
            if (jd && (RES_LAT > 1)) begin
               state_d = J_WAIT;
               cnt_d   = CNT_LOAD;
            end
         end
         J_WAIT: begin
            if (cnt_q == CNT_ONE) begin
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: begin
            state_d = RUN;
            cnt_d   = '0;
         end
      endcase
   end

   // Strobes: in J_WAIT ID only carries flushed bubbles, so inputs are ignored.
   always_comb begin
      stall_raw   = 1'b0;
      stall_j_raw = 1'b0;
      bubble_raw  = 1'b0;
      flush_raw   = 1'b0;
      busy_raw    = 1'b0;
      case (state_q)
         RUN: begin
            if (lu) begin
               stall_raw  = 1'b1;
               bubble_raw = 1'b1;
            end else if (jd) begin
               stall_j_raw = 1'b1;
               flush_raw   = 1'b1;
            end
         end
         J_WAIT: begin
            stall_j_raw = 1'b1;
            flush_raw   = 1'b1;
            busy_raw    = 1'b1;
         end
         default: begin
            stall_raw = 1'b0;
         end
      endcase
   end

   // Everything goes quiet the instant reset is asserted, not at the next edge.
   assign stall    = stall_raw   & rst_n;
   assign stall_j  = stall_j_raw & rst_n;
   assign bubble   = bubble_raw  & rst_n;
   assign flush_if = flush_raw   & rst_n;
   assign busy     = busy_raw    & rst_n;

`ifdef HAZARD_CNT_EN
   logic j_event;

   // A jump is counted once, on the cycle it is accepted from RUN.
   assign j_event = jd & (state_q == RUN) & rst_n;

   sat_cnt #(.W(32)) u_lu_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (stall),
      .cnt_o (lu_cnt)
   );

   sat_cnt #(.W(32)) u_j_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (j_event),
      .cnt_o (j_cnt)
   );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl, run side by side with
// RES_LAT=2 (dut_a) and RES_LAT=1 (dut_b). Counter checks are active when
// HAZARD_CNT_EN is defined.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       id_valid, id_re1, id_re2, id_jump, ex_valid, ex_mem_read;
   logic [4:0] id_rs1, id_rs2, ex_rd;

   logic a_stall, a_stall_j, a_bubble, a_flush, a_busy;
   logic b_stall, b_stall_j, b_bubble, b_flush, b_busy;
`ifdef HAZARD_CNT_EN
   logic [31:0] a_lu_cnt, a_j_cnt, b_lu_cnt, b_j_cnt;
`endif

   always #5 clk = ~clk;

   hazard_ctrl #(.RES_LAT(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_re1(id_re1), .id_re2(id_re2), .id_jump(id_jump), .ex_valid(ex_valid),
      .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .stall(a_stall), .stall_j(a_stall_j),
      .bubble(a_bubble), .flush_if(a_flush), .busy(a_busy)
`ifdef HAZARD_CNT_EN
      , .lu_cnt(a_lu_cnt), .j_cnt(a_j_cnt)
`endif
   );

   hazard_ctrl #(.RES_LAT(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_re1(id_re1), .id_re2(id_re2), .id_jump(id_jump), .ex_valid(ex_valid),
      .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .stall(b_stall), .stall_j(b_stall_j),
      .bubble(b_bubble), .flush_if(b_flush), .busy(b_busy)
`ifdef HAZARD_CNT_EN
      , .lu_cnt(b_lu_cnt), .j_cnt(b_j_cnt)
`endif
   );

   // Output pattern {stall, stall_j, bubble, flush_if, busy}
   localparam logic [4:0] N  = 5'b00000;  // quiet
   localparam logic [4:0] LU = 5'b10100;  // load-use bubble
   localparam logic [4:0] J0 = 5'b01010;  // jump detected in RUN
   localparam logic [4:0] JW = 5'b01011;  // holding in J_WAIT

   int err_cnt = 0;
   int chk_cnt = 0;
   int exp_lu_a = 0, exp_j_a = 0, exp_lu_b = 0, exp_j_b = 0;

   typedef struct {
      string      tag;
      logic [4:0] ea;
      logic [4:0] eb;
   } exp_t;

   exp_t sb_q[$];
   exp_t sb_e;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Monitor: compare the oldest queued expectation on the falling edge.
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         sb_e = sb_q.pop_front();
         $display("txn %-14s lat2=%b exp=%b  lat1=%b exp=%b", sb_e.tag,
                  {a_stall, a_stall_j, a_bubble, a_flush, a_busy}, sb_e.ea,
                  {b_stall, b_stall_j, b_bubble, b_flush, b_busy}, sb_e.eb);
         check({sb_e.tag, "/lat2"}, {27'd0, a_stall, a_stall_j, a_bubble, a_flush, a_busy}, {27'd0, sb_e.ea});
         check({sb_e.tag, "/lat1"}, {27'd0, b_stall, b_stall_j, b_bubble, b_flush, b_busy}, {27'd0, sb_e.eb});
      end
   end

   task automatic set_in(input logic iv, input logic [4:0] r1, input logic re1,
                         input logic [4:0] r2, input logic re2, input logic jmp,
                         input logic ev, input logic mr, input logic [4:0] rd);
      id_valid    = iv;
      id_rs1      = r1;
      id_re1      = re1;
      id_rs2      = r2;
      id_re2      = re2;
      id_jump     = jmp;
      ex_valid    = ev;
      ex_mem_read = mr;
      ex_rd       = rd;
   endtask

   task automatic idle();
      set_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
   endtask

   // Queue the expected outputs for the inputs now applied, then advance a cycle.
   task automatic step(input string tag, input logic [4:0] ea, input logic [4:0] eb);
      exp_t e;
      e.tag = tag;
      e.ea  = ea;
      e.eb  = eb;
      sb_q.push_back(e);
      if (ea[4])    exp_lu_a++;
      if (ea == J0) exp_j_a++;
      if (eb[4])    exp_lu_b++;
      if (eb == J0) exp_j_b++;
      @(posedge clk);
      #1;
   endtask

   task automatic check_counters(input string tag);
`ifdef HAZARD_CNT_EN
      check({tag, "/lu_cnt_a"}, a_lu_cnt, exp_lu_a);
      check({tag, "/j_cnt_a"},  a_j_cnt,  exp_j_a);
      check({tag, "/lu_cnt_b"}, b_lu_cnt, exp_lu_b);
      check({tag, "/j_cnt_b"},  b_j_cnt,  exp_j_b);
`else
      $display("counters %s: not built", tag);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with hazard-provoking inputs: outputs must still be quiet.
      set_in(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd5);
      repeat (2) @(posedge clk);
      #1;
      check("rst_outputs", {22'd0, a_stall, a_stall_j, a_bubble, a_flush, a_busy,
                            b_stall, b_stall_j, b_bubble, b_flush, b_busy}, 32'd0);
      idle();
      #3;
      rst_n = 1'b1;
      step("idle", N, N);

      // Load-use detection and its qualifiers
      set_in(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5); step("lu_rs1", LU, LU);
      idle();                                                        step("lu_clear", N, N);
      set_in(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0); step("lu_x0", N, N);
      set_in(1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7); step("lu_rs2", LU, LU);
      set_in(1'b1, 5'd3, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7); step("no_re2", N, N);
      set_in(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5); step("ex_invalid", N, N);
      set_in(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5); step("not_load", N, N);
      set_in(1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5); step("id_invalid", N, N);
      set_in(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5); step("lu_b2b_0", LU, LU);
      step("lu_b2b_1", LU, LU);

      // Single jump pulse: hold lasts RES_LAT cycles
      set_in(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0); step("jmp", J0, J0);
      idle();                                                        step("jmp_hold", JW, N);
      step("jmp_done", N, N);
      set_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0); step("jmp_novalid", N, N);

      // Load-use arriving during J_WAIT is ignored by the RES_LAT=2 instance
      set_in(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0); step("jmp2", J0, J0);
      set_in(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5); step("jwait_lu", JW, LU);
      idle();                                                        step("jmp2_done", N, N);

      // Simultaneous load-use and jump: load-use first, jump next cycle
      set_in(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd5); step("lu_jmp", LU, LU);
      set_in(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0); step("jmp_after_lu", J0, J0);
      idle();                                                        step("jw_after_lu", JW, N);
      step("clean", N, N);

      // Jump held high: re-detected once back in RUN
      set_in(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0); step("jh0", J0, J0);
      step("jh1", JW, J0);
      step("jh2", J0, J0);
      idle();                                                        step("jh3", JW, N);
      step("jh4", N, N);
      check_counters("mid");

      // Reset asserted mid-J_WAIT with hazards present on the inputs
      set_in(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0); step("jr", J0, J0);
      set_in(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd5);
      rst_n = 1'b0;
      #1;
      check("rst_async", {22'd0, a_stall, a_stall_j, a_bubble, a_flush, a_busy,
                          b_stall, b_stall_j, b_bubble, b_flush, b_busy}, 32'd0);
      exp_lu_a = 0; exp_j_a = 0; exp_lu_b = 0; exp_j_b = 0;
      check_counters("rst");
      @(posedge clk);
      #1;
      check("rst_held", {22'd0, a_stall, a_stall_j, a_bubble, a_flush, a_busy,
                         b_stall, b_stall_j, b_bubble, b_flush, b_busy}, 32'd0);
      idle();
      #2;
      rst_n = 1'b1;
      step("post_rst", N, N);
      set_in(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0); step("jpr", J0, J0);
      idle();                                                        step("jpr1", JW, N);
      step("jpr2", N, N);
      check_counters("end");

      check("sb_empty", sb_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
